// File: rtl/bcd2bin_if.sv
//------------------------------------------------------------------------------
// Module  : bcd2bin_if
// Brief   : Input/output handshake bundle for the BCD-to-binary converter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd2bin_if #(
    parameter int DIGITS = 4,
    parameter int BW     = 14
);
    logic [4*DIGITS-1:0] bcd;
    logic                in_valid;
    logic                in_ready;
    logic [BW-1:0]       bin;
    logic                err;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output bcd, in_valid, out_ready,
        input  in_ready, bin, err, out_valid
    );

    modport slave (
        input  bcd, in_valid, out_ready,
        output in_ready, bin, err, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/bcd2bin.sv
//------------------------------------------------------------------------------
// Module  : bcd2bin
// Brief   : Serial packed-BCD to binary converter, one digit per clock, MSD first.
//           Optional macro BCD2BIN_ERR_CHECK_EN flags nibbles > 9.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd2bin #(
    parameter int DIGITS = 4,
    parameter int BW     = 14
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    bcd2bin_if.slave    bus
);
    localparam int            CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [4*DIGITS-1:0] r_sh;
    logic [BW-1:0]       r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [BW-1:0]       r_bin;

    logic [3:0]          w_digit;
    logic [BW-1:0]       w_acc_nxt;

    assign w_digit   = r_sh[4*DIGITS-1 -: 4];
    // Wraps modulo 2^BW by construction when BW is undersized.
    assign w_acc_nxt = r_acc * BW'(10) + BW'(w_digit);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bin       = r_bin;

`ifdef BCD2BIN_ERR_CHECK_EN
    logic r_flag;
    logic r_err;
    logic w_bad;

    assign w_bad   = (w_digit > 4'd9);
    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_bin       <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
            r_flag      <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_sh       <= bus.bcd;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CONV;
`ifdef BCD2BIN_ERR_CHECK_EN
                        r_flag     <= 1'b0;
`endif
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_CONV: begin
                    r_acc <= w_acc_nxt;
                    r_sh  <= r_sh << 4;
                    r_cnt <= r_cnt + CW'(1);
`ifdef BCD2BIN_ERR_CHECK_EN
                    r_flag <= r_flag | w_bad;
`endif
                    if (r_cnt == C_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
`ifdef BCD2BIN_ERR_CHECK_EN
                        r_err <= r_flag | w_bad;
                        r_bin <= (r_flag | w_bad) ? '1 : w_acc_nxt;
`else
                        r_bin <= w_acc_nxt;
`endif
                    end
                end
                S_DONE: begin
                    // Only sampled while in DONE, so out_valid is high for at least one full cycle.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bcd2bin.sv
//------------------------------------------------------------------------------
// Module  : tb_bcd2bin
// Brief   : Directed self-checking bench for bcd2bin (DIGITS=4, BW=14).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd2bin;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    bcd2bin_if #(.DIGITS(4), .BW(14)) bus ();

    bcd2bin #(.DIGITS(4), .BW(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Caller is at a negedge with in_ready=1; hold = extra cycles out_ready stays low.
    task automatic convert(input string tag, input logic [15:0] w, input logic [13:0] eb,
                           input logic ee, input int hold);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.bcd = w;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.bcd = 16'hFFFF;
        chk({tag, "_ov0"}, 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_ovlat"}, 32'(bus.out_valid), 32'd0);
        end
        step();
        chk({tag, "_ov"},  32'(bus.out_valid), 32'd1);
        chk({tag, "_bin"}, 32'(bus.bin), 32'(eb));
        chk({tag, "_err"}, 32'(bus.err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hov"},  32'(bus.out_valid), 32'd1);
            chk({tag, "_hbin"}, 32'(bus.bin), 32'(eb));
            chk({tag, "_hrdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_drain_ov"},  32'(bus.out_valid), 32'd0);
        chk({tag, "_drain_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] words [3];
        logic [13:0] exps  [3];
        int          t_acc [3];
        int          n;
        logic [15:0] sw;

        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0;
        bus.bcd = 16'h0000;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        chk("rst_ov",  32'(bus.out_valid), 32'd0);
        chk("rst_bin", 32'(bus.bin), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_pre", 32'(bus.in_ready), 32'd0);
        step();
        chk("rel_rdy", 32'(bus.in_ready), 32'd1);

        convert("zero", 16'h0000, 14'd0, 1'b0, 0);
        convert("nines", 16'h9999, 14'h270F, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            sw = 16'(((i / 10) << 4) | (i % 10));
            convert("sweep", sw, 14'(i), 1'b0, 0);
        end
`ifdef BCD2BIN_ERR_CHECK_EN
        convert("badnib", 16'h12A4, 14'h3FFF, 1'b1, 0);
`else
        convert("badnib", 16'h12A4, 14'd1304, 1'b0, 0);
`endif
        convert("stall", 16'h0042, 14'd42, 1'b0, 5);

        // Back-to-back stream
        words[0] = 16'h0123; words[1] = 16'h4567; words[2] = 16'h0890;
        exps[0]  = 14'd123;  exps[1]  = 14'd4567; exps[2]  = 14'd890;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bcd       = words[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!bus.in_ready && n < 20) begin step(); n++; end
            chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
            t_acc[k] = cyc;
            bus.bcd = words[k];
            step();
            n = 0;
            while (!bus.out_valid && n < 20) begin step(); n++; end
            chk("b2b_ov",  32'(bus.out_valid), 32'd1);
            chk("b2b_bin", 32'(bus.bin), 32'(exps[k]));
        end
        bus.in_valid = 1'b0;
        chk("b2b_gap1", 32'(t_acc[1] - t_acc[0]), 32'd6);
        chk("b2b_gap2", 32'(t_acc[2] - t_acc[1]), 32'd6);
        step(); step();
        chk("b2b_nodup", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Reset in the 2nd CONV cycle
        chk("rc_rdy", 32'(bus.in_ready), 32'd1);
        bus.bcd = 16'h0777;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rc_ov",  32'(bus.out_valid), 32'd0);
        chk("rc_bin", 32'(bus.bin), 32'd0);
        chk("rc_err", 32'(bus.err), 32'd0);
        chk("rc_rdy0", 32'(bus.in_ready), 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rc_rdy_pre", 32'(bus.in_ready), 32'd0);
        step();
        chk("rc_rdy1", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rc_nostale", 32'(bus.out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
